// File: rtl/divider_pipelined_multi.sv
// Pipelined restoring divider for div/divu/rem/remu.
// Signs are stripped up front; the pipe works on magnitudes.
module divider_pipelined_multi #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_STAGE = 4,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  localparam int STAGES = WIDTH / BITS_PER_STAGE;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             qs;
    logic             rs;
    logic             dz;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } st_t;

  function automatic st_t step(input st_t s);
    st_t            r;
    logic [WIDTH:0] t;
    logic [WIDTH-1:0] sh;
    r = s;
    for (int k = 0; k < BITS_PER_STAGE; k++) begin
      sh    = {r.rem[WIDTH-2:0], r.dvd[WIDTH-1]};
      t     = {1'b0, sh} - {1'b0, r.dvs};
      r.rem = t[WIDTH] ? sh : t[WIDTH-1:0];
      r.quo = {r.quo[WIDTH-2:0], ~t[WIDTH]};
      r.dvd = {r.dvd[WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

  // With a zero divisor every trial succeeds, so rem ends as
  // |dividend| and re-signing it restores the original dividend.
  function automatic logic [WIDTH-1:0] fin_res(input st_t s);
    if (!s.op[1]) begin
      if (s.dz) return '1;
      return s.qs ? -s.quo : s.quo;
    end
    return s.rs ? -s.rem : s.rem;
  endfunction

  st_t              pre;
  st_t              pipe [STAGES];
  st_t              nxt  [STAGES];
  logic             sgn;
  logic             sd;
  logic             sv;
  logic [WIDTH-1:0] res;

  // Condition operands into magnitudes plus sign/zero flags
  always_comb begin
    sgn      = ~i_op[0];
    sd       = sgn & i_dividend[WIDTH-1];
    sv       = sgn & i_divisor[WIDTH-1];
    pre      = '0;
    pre.v    = i_valid;
    pre.dvd  = sd ? -i_dividend : i_dividend;
    pre.dvs  = sv ? -i_divisor : i_divisor;
    pre.qs   = sd ^ sv;
    pre.rs   = sd;
    pre.dz   = (i_divisor == '0);
    pre.op   = i_op;
    pre.tag  = i_tag;
  end

  // Stage 0 latches conditioned operands; each later hop,
  // including the hop into the output register, iterates.
  assign nxt[0] = pre;
  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    assign nxt[g] = step(pipe[g-1]);
  end

  assign res = fin_res(step(pipe[STAGES-1]));

  // Advance unless stalled; flush kills valid bits regardless
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_tag    <= '0;
    end else begin
      if (!stall) begin
        for (int i = 0; i < STAGES; i++) pipe[i] <= nxt[i];
        o_valid  <= pipe[STAGES-1].v;
        o_result <= res;
        o_tag    <= pipe[STAGES-1].tag;
      end
      if (flush) begin
        for (int i = 0; i < STAGES; i++) pipe[i].v <= 1'b0;
        o_valid <= 1'b0;
      end
    end
  end

  // Anything in flight or on the output marks the unit busy
  always_comb begin
    o_busy = o_valid;
    for (int i = 0; i < STAGES; i++) o_busy = o_busy | pipe[i].v;
  end

endmodule

// File: tb/tb_divider_pipelined_multi.sv
// Bench for divider_pipelined_multi: vector table, corner
// sequences and random ops against an arithmetic model.
module tb_divider_pipelined_multi;

  parameter int W   = 32;
  parameter int BPS = 4;
  localparam int TW = 5;
  localparam int L  = W / BPS + 1;

  logic          clk = 1'b0;
  logic          rst, stall, flush, i_valid;
  logic [1:0]    i_op;
  logic [W-1:0]  i_dividend, i_divisor;
  logic [TW-1:0] i_tag;
  logic          o_valid, o_busy;
  logic [W-1:0]  o_result;
  logic [TW-1:0] o_tag;

  always #5 clk = ~clk;

  divider_pipelined_multi #(
    .WIDTH(W), .BITS_PER_STAGE(BPS), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .i_valid(i_valid), .i_op(i_op),
    .i_dividend(i_dividend), .i_divisor(i_divisor),
    .i_tag(i_tag), .o_valid(o_valid), .o_result(o_result),
    .o_tag(o_tag), .o_busy(o_busy)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
  } exp_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
  } vec_t;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  int     pops  = 0;
  int     pop_cyc [32];
  logic   mon = 1'b0;
  exp_t   q[$];
  vec_t   tbl [16];
  logic [W-1:0] mn;

  function automatic logic [W-1:0] model(
    input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] m;
    m = '0;
    m[W-1] = 1'b1;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0]) begin
      if (a == m && b == '1) return op[1] ? '0 : m;
      return op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i += 32) r = (r << 32) ^ W'($urandom);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    logic [W-1:0] r;
    case ($urandom % 8)
      0: r = '0;
      1: r = '1;
      2: begin r = '0; r[W-1] = 1'b1; end
      3, 4: r = W'($urandom % 16);
      default: r = rnd();
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic tick();
    logic st;
    exp_t e;
    st = stall;
    @(posedge clk);
    #1;
    cyc++;
    if (mon && o_valid && !st) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected: got o_valid tag=%0d res=%h want none",
                 o_tag, o_result);
      end else begin
        e = q.pop_front();
        chk("res", o_result, e.res);
        chk("tag", W'(o_tag), W'(e.tag));
        pop_cyc[e.tag] = cyc;
        pops++;
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag,
                       input logic [W-1:0] e, input bit push);
    exp_t x;
    i_valid    = 1'b1;
    i_op       = op;
    i_dividend = a;
    i_divisor  = b;
    i_tag      = tag;
    if (push) begin
      x.tag = tag;
      x.res = e;
      q.push_back(x);
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int k;
    k = 0;
    i_valid = 1'b0;
    while (q.size() > 0 && k < 4 * L + 8) begin
      tick();
      k++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t0, k, p0;
    logic [1:0]   op;
    logic [W-1:0] a, b, ra;

    mn = '0;
    mn[W-1] = 1'b1;
    tbl[0]  = '{2'b00, W'(-7), W'(2), W'(-3)};
    tbl[1]  = '{2'b10, W'(-7), W'(2), W'(-1)};
    tbl[2]  = '{2'b01, W'(-7), W'(2), {1'b0, {(W-3){1'b1}}, 2'b00}};
    tbl[3]  = '{2'b11, W'(-7), W'(2), W'(1)};
    tbl[4]  = '{2'b00, mn, '1, mn};
    tbl[5]  = '{2'b10, mn, '1, '0};
    tbl[6]  = '{2'b00, W'(5), '0, '1};
    tbl[7]  = '{2'b00, W'(-5), '0, '1};
    tbl[8]  = '{2'b10, W'(-5), '0, W'(-5)};
    tbl[9]  = '{2'b11, W'(5), '0, W'(5)};
    tbl[10] = '{2'b01, W'(100), W'(7), W'(14)};
    tbl[11] = '{2'b11, W'(100), W'(7), W'(2)};
    tbl[12] = '{2'b00, W'(7), W'(-2), W'(-3)};
    tbl[13] = '{2'b10, W'(7), W'(-2), W'(1)};
    tbl[14] = '{2'b01, mn, '1, '0};
    tbl[15] = '{2'b11, mn, '1, mn};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    i_valid = 1'b1; i_op = 2'b00;
    i_dividend = W'(9); i_divisor = W'(2); i_tag = '0;
    tick();
    tick();
    chk("rst_valid", W'(o_valid), '0);
    chk("rst_result", o_result, '0);
    chk("rst_busy", W'(o_busy), '0);
    rst = 1'b0;
    i_valid = 1'b0;
    mon = 1'b1;

    t0 = cyc;
    issue(2'b00, W'(100), W'(7), 5'd3, W'(14), 1'b1);
    drain();
    chk("lat_first", W'(pop_cyc[3] - t0), W'(L));

    for (int i = 0; i < 16; i++)
      issue(tbl[i].op, tbl[i].a, tbl[i].b, TW'(i), tbl[i].e, 1'b1);
    drain();

    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom);
      a  = rnd_opnd();
      b  = rnd_opnd();
      issue(op, a, b, TW'(i), model(op, a, b), 1'b1);
    end
    drain();
    chk("b2b_count", W'(pops - p0), W'(20));
    chk("b2b_span", W'(pop_cyc[19] - pop_cyc[0]), W'(19));

    idle(2);
    t0 = cyc;
    a  = W'(-1000);
    b  = W'(7);
    ra = model(2'b00, a, b);
    issue(2'b00, a, b, 5'd0, ra, 1'b1);
    issue(2'b11, W'(1000), W'(9), 5'd1, W'(1), 1'b1);
    issue(2'b01, W'(1000), W'(9), 5'd2, W'(111), 1'b1);
    idle(2);
    stall = 1'b1;
    i_valid = 1'b1;
    i_tag = 5'd31;
    repeat (4) tick();
    chk("stall_busy", W'(o_busy), W'(1));
    stall = 1'b0;
    i_valid = 1'b0;
    k = 0;
    while (q.size() == 3 && k < 3 * L) begin
      tick();
      k++;
    end
    chk("stall_lat", W'(pop_cyc[0] - t0), W'(L + 4));
    stall = 1'b1;
    tick();
    tick();
    chk("hold_valid", W'(o_valid), W'(1));
    chk("hold_result", o_result, ra);
    chk("hold_tag", W'(o_tag), '0);
    stall = 1'b0;
    drain();
    chk("stall_next", W'(pop_cyc[1] - pop_cyc[0]), W'(3));

    idle(2);
    issue(2'b01, W'(50), W'(5), 5'd4, '0, 1'b0);
    issue(2'b01, W'(60), W'(5), 5'd5, '0, 1'b0);
    flush = 1'b1;
    issue(2'b01, W'(70), W'(5), 5'd6, '0, 1'b0);
    flush = 1'b0;
    chk("flush_busy", W'(o_busy), '0);
    chk("flush_valid", W'(o_valid), '0);
    t0 = cyc;
    issue(2'b00, W'(-81), W'(9), 5'd7, W'(-9), 1'b1);
    drain();
    chk("flush_next_lat", W'(pop_cyc[7] - t0), W'(L));

    issue(2'b00, W'(8), W'(2), 5'd8, '0, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    chk("flush_stall_busy", W'(o_busy), '0);
    idle(L + 2);

    issue(2'b00, W'(8), W'(2), 5'd9, '0, 1'b0);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", W'(o_busy), '0);
    idle(L + 2);

    for (int i = 0; i < 60; i++) begin
      stall = ($urandom % 5 == 0);
      if (!stall && ($urandom % 3 != 0)) begin
        op = 2'($urandom);
        a  = rnd_opnd();
        b  = rnd_opnd();
        issue(op, a, b, TW'(i % 32), model(op, a, b), 1'b1);
      end else begin
        i_valid = stall ? 1'($urandom) : 1'b0;
        tick();
      end
    end
    stall = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
